vc_req_credit_num_vc: RTL and testbench
=======================================

VC_REQ_CREDIT_NUM_VC -- requirements
Module: vc_req_credit_num_vc

Interface
REQ-001 Parameter NUM_VC, default 1: number of VCs per VN; width of every per-VC vector.
REQ-002 Parameter NUM_VN, default 3: number of VNs; carried for instantiation consistency only, with no functional effect.
REQ-003 Parameter CREDITS, default 4: downstream buffer depth per VC, in flits; legal range 1..255.
REQ-004 Derived CW = Log2(CREDITS+1): credit counter width.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 Port pending_in, input, NUM_VC: bit i high means VC i holds a flit ready to send.
REQ-008 Port tail_in, input, NUM_VC: bit i high means the VC i head flit is a packet tail.
REQ-009 Port grant_in, input, NUM_VC: one-hot grant from the round-robin arbiter; all-zero means no grant.
REQ-010 Port credit_in, input, NUM_VC: one-cycle pulse per returned downstream credit, per VC.
REQ-011 Port req_out, output, NUM_VC: per-VC request vector that drives the arbiter request input.
REQ-012 Port grants_out, output, NUM_VC: registered accepted grant that drives the arbiter token-update input.
REQ-013 Port send_out, output, NUM_VC: one-hot flit-launch strobe, combinational from grant acceptance.
REQ-014 Port pkt_active_out, output, NUM_VC: bit i high while VC i is mid-packet.
REQ-015 Port credit_cnt_out, output, NUM_VC*CW: packed credit counters; VC i occupies bits [i*CW +: CW].
REQ-016 Port err_out, output, 2: sticky errors; bit0 = credit overflow, bit1 = illegal grant.

Function
REQ-017 req_out[i] SHALL equal pending_in[i] AND (cnt[i] != 0), combinational, with zero latency.
REQ-018 Grant accept: acc[i] = grant_in[i] AND req_out[i] AND grant_in is one-hot.
REQ-019 send_out SHALL equal acc in the same cycle.
REQ-020 grants_out SHALL be acc registered, with 1-cycle latency.
REQ-021 Counter update rules:
- acc[i] only: cnt[i] -1.
- credit_in[i] only: cnt[i] +1.
- Both in the same cycle: cnt[i] unchanged.
REQ-022 Saturation: credit_in[i] with no acc[i] while cnt[i]==CREDITS SHALL hold cnt[i]==CREDITS and never wrap.
REQ-023 A zero-credit VC SHALL never be accepted; this is guaranteed by REQ-017 and REQ-018.
REQ-024 Per-VC FSM: states IDLE and PKT.
- IDLE -> PKT on acc[i] AND NOT tail_in[i].
- PKT -> IDLE on acc[i] AND tail_in[i].
- IDLE stays IDLE on a single-flit packet (acc with tail).
REQ-025 pkt_active_out[i] SHALL be high exactly when VC i is in state PKT.
REQ-026 A grant that is non-one-hot, or that targets a VC with req_out low, SHALL be ignored: no counter change, no send, no FSM move.
REQ-027 VCs are independent: simultaneous credits on multiple VCs all apply in the same cycle.

Reset
REQ-028 While rst_n is low at a clock edge, the block SHALL:
- set every cnt to CREDITS;
- set every FSM to IDLE;
- clear grants_out and err_out.
REQ-029 During reset, req_out, send_out and pkt_active_out SHALL be forced to zero regardless of inputs.
REQ-030 Reset asserted mid-packet SHALL discard the PKT state; no credits are restored beyond CREDITS.

Configuration
REQ-031 Macro VC_REQ_CREDIT_ERR_EN SHALL control error detection.
REQ-032 With the macro defined, the block SHALL set err_out bits stickily:
- bit0 on credit_in[i] with no acc[i] at cnt[i]==CREDITS;
- bit1 on a grant ignored per REQ-026;
- both bits clear only on reset.
REQ-033 Without the macro, err_out SHALL be tied to zero and no detection logic is synthesised; all other behaviour is identical.

Verification
REQ-034 NUM_VC=2, CREDITS=2, reset release, pending_in=2'b11: req_out=2'b11 and credit_cnt_out shows 2,2 on the first cycle.
REQ-035 Grant VC0 twice with no credits returned -> cnt0=0 and req_out[0]=0 while pending_in[0]=1; a grant_in=2'b01 on the next cycle is ignored and, with the macro defined, sets err_out[1].
REQ-036 In one cycle, grant VC1 (acc) and pulse credit_in[1] -> cnt1 unchanged; send_out=2'b10; grants_out=2'b10 on the following cycle.
REQ-037 credit_in[0] pulse at cnt0=2 -> cnt0 stays 2; err_out=2'b01 with the macro defined, 2'b00 without it.
REQ-038 Grant VC0 with tail_in=0, then grant with tail_in=1 -> pkt_active_out[0] high for exactly 1 cycle between the two grants; drop rst_n while in PKT -> all counters read CREDITS and pkt_active_out=0 one edge later.

Source files
------------

// File: rtl/vc_req_credit_num_vc.sv
// Per-VC credit tracking, request gating and packet-state tracking for a VC allocator.
// Optional sticky error detection is built when VC_REQ_CREDIT_ERR_EN is defined.
module vc_req_credit_num_vc #(
  parameter int NUM_VC  = 1,
  parameter int NUM_VN  = 3,
  parameter int CREDITS = 4,
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_VC-1:0]    pending_in,
  input  logic [NUM_VC-1:0]    tail_in,
  input  logic [NUM_VC-1:0]    grant_in,
  input  logic [NUM_VC-1:0]    credit_in,
  output logic [NUM_VC-1:0]    req_out,
  output logic [NUM_VC-1:0]    grants_out,
  output logic [NUM_VC-1:0]    send_out,
  output logic [NUM_VC-1:0]    pkt_active_out,
  output logic [NUM_VC*CW-1:0] credit_cnt_out,
  output logic [1:0]           err_out
);

  if (NUM_VN < 1 || CREDITS < 1 || CREDITS > 255) begin : g_bad_cfg
    $error("vc_req_credit_num_vc: illegal NUM_VN or CREDITS");
  end

  // Handshake: a VC launches a flit (send_out) in the same cycle the arbiter
  // grant is accepted; acceptance needs a one-hot grant on a requesting VC.
  typedef enum logic {IDLE, PKT} state_t;

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0]     cnt_q [NUM_VC];
  logic [CW-1:0]     cnt_d [NUM_VC];
  state_t            state_q [NUM_VC];
  state_t            state_d [NUM_VC];
  logic [NUM_VC-1:0] grants_q;
  logic [NUM_VC-1:0] has_credit;
  logic [NUM_VC-1:0] acc;
  logic              grant_onehot;

  assign grant_onehot = (grant_in != '0) &&
                        ((grant_in & (grant_in - NUM_VC'(1))) == '0);

  always_comb begin
    has_credit     = '0;
    pkt_active_out = '0;
    credit_cnt_out = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      has_credit[i]            = (cnt_q[i] != '0);
      pkt_active_out[i]        = rst_n && (state_q[i] == PKT);
      credit_cnt_out[i*CW +: CW] = cnt_q[i];
    end
  end

  assign req_out    = rst_n ? (pending_in & has_credit) : '0;
  assign acc        = grant_in & req_out & {NUM_VC{grant_onehot}};
  assign send_out   = acc;
  assign grants_out = grants_q;

  // Counter next state: a grant and a credit in the same cycle cancel out.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (acc[i] && !credit_in[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end else if (credit_in[i] && !acc[i] && (cnt_q[i] != FULL)) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:    if (acc[i] && !tail_in[i]) state_d[i] = PKT;
        PKT:     if (acc[i] &&  tail_in[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grants_q <= '0;
      for (int i = 0; i < NUM_VC; i++) begin
        cnt_q[i]   <= FULL;
        state_q[i] <= IDLE;
      end
    end else begin
      grants_q <= acc;
      for (int i = 0; i < NUM_VC; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

`ifdef VC_REQ_CREDIT_ERR_EN
  logic [NUM_VC-1:0] full_vec;
  logic [1:0]        err_q;
  logic [1:0]        err_d;

  always_comb begin
    full_vec = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      full_vec[i] = (cnt_q[i] == FULL);
    end
  end

  // Overflow: credit returned to a full counter; illegal: any grant not accepted.
  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | (|(credit_in & ~acc & full_vec));
    err_d[1] = err_q[1] | ((grant_in != '0) && (acc == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 2'b00;
`endif

endmodule

// File: tb/tb_vc_req_credit_num_vc.sv
// Directed bench for vc_req_credit_num_vc with NUM_VC=2, CREDITS=2: a driver pushes
// hand-computed expected outputs per cycle and a negedge monitor compares them.
module tb_vc_req_credit_num_vc;

  localparam int NUM_VC  = 2;
  localparam int CREDITS = 2;
  localparam int CW      = 2;
  localparam int EW      = 4 * NUM_VC + NUM_VC * CW + 2;
`ifdef VC_REQ_CREDIT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [NUM_VC-1:0]    pending_in;
  logic [NUM_VC-1:0]    tail_in;
  logic [NUM_VC-1:0]    grant_in;
  logic [NUM_VC-1:0]    credit_in;
  logic [NUM_VC-1:0]    req_out;
  logic [NUM_VC-1:0]    grants_out;
  logic [NUM_VC-1:0]    send_out;
  logic [NUM_VC-1:0]    pkt_active_out;
  logic [NUM_VC*CW-1:0] credit_cnt_out;
  logic [1:0]           err_out;

  vc_req_credit_num_vc #(
    .NUM_VC (NUM_VC),
    .NUM_VN (3),
    .CREDITS(CREDITS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pending_in    (pending_in),
    .tail_in       (tail_in),
    .grant_in      (grant_in),
    .credit_in     (credit_in),
    .req_out       (req_out),
    .grants_out    (grants_out),
    .send_out      (send_out),
    .pkt_active_out(pkt_active_out),
    .credit_cnt_out(credit_cnt_out),
    .err_out       (err_out)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_cmp;
  int            n_err;

  // Driver: applies inputs just after a rising edge and queues the outputs
  // expected until the next rising edge ({req, send, grants, pkt, cnt1, cnt0, err}).
  task automatic step(input string nm, input logic rst, input logic [1:0] pend,
                      input logic [1:0] tail, input logic [1:0] gnt, input logic [1:0] cred,
                      input logic [1:0] e_req, input logic [1:0] e_send,
                      input logic [1:0] e_gnts, input logic [1:0] e_pkt,
                      input logic [3:0] e_cnt, input logic [1:0] e_err);
    @(posedge clk);
    #1;
    rst_n      = rst;
    pending_in = pend;
    tail_in    = tail;
    grant_in   = gnt;
    credit_in  = cred;
    exp_q.push_back({e_req, e_send, e_gnts, e_pkt, e_cnt, e_err});
    name_q.push_back(nm);
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        string         nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {req_out, send_out, grants_out, pkt_active_out, credit_cnt_out, err_out};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s: got req=%b send=%b gnts=%b pkt=%b cnt=%b err=%b, expected req=%b send=%b gnts=%b pkt=%b cnt=%b err=%b",
                   nm, a[13:12], a[11:10], a[9:8], a[7:6], a[5:2], a[1:0],
                   e[13:12], e[11:10], e[9:8], e[7:6], e[5:2], e[1:0]);
        end
      end
    end
  end

  initial begin
    logic [1:0] e_ovf;
    logic [1:0] e_both;
    logic [1:0] e_ill;
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    pending_in = 2'b11;
    tail_in    = 2'b00;
    grant_in   = 2'b00;
    credit_in  = 2'b00;
    e_ovf      = ERR_EN ? 2'b01 : 2'b00;
    e_both     = ERR_EN ? 2'b11 : 2'b00;
    e_ill      = ERR_EN ? 2'b10 : 2'b00;
    repeat (2) @(posedge clk);

    //    name           rst pend   tail   gnt    cred   req    send   gnts   pkt    cnt      err
    step("reset_force",  0, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1010, 2'b00);
    step("first_cycle",  1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 4'b1010, 2'b00);
    step("sat_grant0",   1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 4'b1010, e_ovf);
    step("grant0_again", 1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00, 4'b1001, e_ovf);
    step("zero_credit",  1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 4'b1000, e_ovf);
    step("ill_flag",     1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 4'b1000, e_both);
    step("non_onehot",   1, 2'b11, 2'b00, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 4'b1001, e_both);
    step("acc_and_cred", 1, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 4'b1010, e_both);
    step("grants_reg",   1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 4'b1010, e_both);
    step("pkt_head",     1, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 4'b1010, e_both);
    step("pkt_tail",     1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 4'b1001, e_both);
    step("pkt_done",     1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 4'b1000, e_both);
    step("pkt1_head",    1, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 4'b1000, e_both);
    step("rst_mid_pkt",  0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 4'b0100, e_both);
    step("post_reset",   1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 4'b1010, 2'b00);
    step("grant1",       1, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 4'b1001, 2'b00);
    step("dual_credit",  1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 4'b0101, 2'b00);
    step("grant_no_req", 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1010, 2'b00);
    step("ill_pend_low", 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 4'b1010, e_ill);

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      if (exp_q.size() > 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
